// File: rtl/scan_pattern_sequencer.sv
// Test-pattern sequencer for the scan-wrapped AndOr/SR/XorNor core: applies host
// stimulus vectors, captures X/Y/Z after a fixed latency and reports masked pass/fail.
module scan_pattern_sequencer #(
  parameter int CAPTURE_LAT = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             abort,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [3:0]       pat_stim,
  input  logic [2:0]       pat_exp,
  input  logic [2:0]       pat_mask,
  input  logic             pat_last,
  output logic             dut_clr,
  output logic [3:0]       dut_abcd,
  input  logic [2:0]       dut_xyz,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_pass,
  output logic [2:0]       res_resp,
  output logic [CNT_W-1:0] res_idx,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_WAIT, S_CAPTURE, S_REPORT, S_DONE
  } state_e;

  localparam logic [3:0]       LAT     = 4'(CAPTURE_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [3:0]       abcd_q, abcd_d;
  logic [2:0]       exp_q, exp_d;
  logic [2:0]       mask_q, mask_d;
  logic             last_q, last_d;
  logic [2:0]       resp_q, resp_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] ridx_q, ridx_d;
  logic             mismatch;

  assign mismatch = |((dut_xyz ^ exp_q) & mask_q);

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    abcd_d  = abcd_q;
    exp_d   = exp_q;
    mask_d  = mask_q;
    last_d  = last_q;
    resp_d  = resp_q;
    pass_d  = pass_q;
    ridx_d  = ridx_q;

    if (abort) begin
      // Abort overrides start, accept and result handshakes alike.
      state_d = S_IDLE;
      abcd_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_CLEAR;
            abcd_d  = '0;
            fail_d  = '0;
            idx_d   = '0;
          end
        end
        S_CLEAR: state_d = S_LOAD;
        S_LOAD: begin
          if (pat_valid) begin
            abcd_d  = pat_stim;
            exp_d   = pat_exp;
            mask_d  = pat_mask;
            last_d  = pat_last;
            cnt_d   = LAT;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          resp_d  = dut_xyz;
          pass_d  = ~mismatch;
          ridx_d  = idx_q;
          if (mismatch && (fail_q != CNT_MAX)) fail_d = fail_q + CNT_W'(1);
          state_d = S_REPORT;
        end
        S_REPORT: begin
          if (res_ready) begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = last_q ? S_DONE : S_LOAD;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers update with non-blocking assignments so all flops see pre-edge values.
  // NOTE: the vector/result registers are plain flops, so all of them reset alongside the FSM.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      fail_q  <= '0;
      abcd_q  <= '0;
      exp_q   <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
      resp_q  <= '0;
      pass_q  <= 1'b0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      abcd_q  <= abcd_d;
      exp_q   <= exp_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      resp_q  <= resp_d;
      pass_q  <= pass_d;
      ridx_q  <= ridx_d;
    end
  end

  assign pat_ready = (state_q == S_LOAD);
  assign dut_clr   = (state_q == S_CLEAR);
  assign res_valid = (state_q == S_REPORT);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign dut_abcd  = abcd_q;
  assign res_pass  = pass_q;
  assign res_resp  = resp_q;
  assign res_idx   = ridx_q;
  assign fail_cnt  = fail_q;

endmodule

// File: doc/scan_pattern_sequencer.md
Name: scan_pattern_sequencer

Overview:
- Test-pattern sequencer sitting directly upstream (and around) the scan-wrapped AndOr/SR/XorNor core.
- Accepts stimulus/expected-response vectors from a host over a valid/ready handshake and drives A..D into the wrapper's input flops.
- Samples X/Y/Z from the wrapper's output flops after a fixed capture latency, compares against the expected vector under a mask, and returns per-vector results plus a running fail count.
- Shares the wrapper's clock; issues the wrapper's active-high clear at session start.

Parameters:
- CAPTURE_LAT, 2, clock edges from stimulus change until wrapper outputs X/Y/Z reflect it (input flop + output flop); legal range 1..15.
- CNT_W, 8, width of the vector and fail counters.

Ports:
- clk  input  1  single clock; also drives the wrapper's scan clock.
- clr_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a test session; honoured only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE from any state.
- pat_valid  input  1  host vector valid.
- pat_ready  output  1  sequencer can accept a vector.
- pat_stim  input  4  stimulus {A,B,C,D}, bit3 = A.
- pat_exp  input  3  expected {X,Y,Z}, bit2 = X.
- pat_mask  input  3  1 = compare this bit.
- pat_last  input  1  final vector of session.
- dut_clr  output  1  active-high clear to wrapper flops.
- dut_abcd  output  4  registered stimulus to wrapper A..D.
- dut_xyz  input  3  wrapper outputs {X,Y,Z}.
- res_valid  output  1  result valid.
- res_ready  input  1  host accepts result.
- res_pass  output  1  (dut_xyz ^ exp) & mask == 0.
- res_resp  output  3  captured {X,Y,Z}.
- res_idx  output  CNT_W  index of vector (0-based).
- fail_cnt  output  CNT_W  failing vectors this session, saturating.
- busy  output  1  high in any state but IDLE.
- done  output  1  one-cycle pulse at session end.

Behaviour:
- Reset (clr_n=0, async):
  - state=IDLE; all outputs 0 (dut_clr=0, dut_abcd=0, pat_ready=0, res_* = 0, fail_cnt=0, done=0).
  - Internal latency counter and vector index = 0.
- IDLE:
  - start=1 -> CLEAR.
  - fail_cnt and index hold their last session values until the next start.
- CLEAR (1 cycle):
  - dut_clr=1, dut_abcd=0, fail_cnt=0, index=0 -> LOAD.
- LOAD:
  - pat_ready=1.
  - On the edge where pat_valid&pat_ready: register stim/exp/mask/last, dut_abcd<=pat_stim, latency counter<=CAPTURE_LAT -> WAIT.
  - pat_ready=0 in every other state.
- WAIT:
  - Counter decrements each edge; at 0 -> CAPTURE.
  - dut_xyz is sampled exactly CAPTURE_LAT+1 edges after the accept edge (default: 3rd edge).
- CAPTURE (1 cycle):
  - res_resp<=dut_xyz; res_pass computed with mask; res_idx<=index.
  - If fail, fail_cnt<=fail_cnt+1, saturating at all-ones.
  - -> REPORT.
- REPORT:
  - res_valid=1; res_* stable while res_valid&~res_ready.
  - On res_ready edge: index<=index+1 (wraps modulo 2^CNT_W); if last -> DONE else LOAD.
- DONE (1 cycle):
  - done=1 -> IDLE.
- dut_abcd:
  - Holds the last stimulus through LOAD of the next vector; SR state in the core depends on history.
  - Not changed between vectors except at accept.
- abort=1 (any state, including simultaneously with start/pat_valid/res_ready):
  - Wins over all other inputs; next state IDLE.
  - dut_abcd<=0, res_valid<=0; no vector is accepted; no done pulse.
  - fail_cnt and index hold.
- start while busy is ignored.
- mask=0 always passes.
- Mid-session clr_n assertion: immediate reset values; the host must restart.

Test Plan:
- Reset then start; CLEAR lasts exactly 1 cycle -> dut_clr=1 for exactly one cycle; pat_ready rises the next cycle; dut_abcd=0.
- One vector stim=4'b1110, exp=3'b101, mask=3'b111, last=1, with a wrapper model returning 101 at the capture edge -> accept edge E0, dut_xyz sampled at E0+3, res_valid at E0+4 with res_pass=1, res_idx=0, fail_cnt=0; done pulses 1 cycle after res_ready.
- Three vectors, middle one mismatching on bit X only -> res_pass sequence 1,0,1; fail_cnt=1; same vector with mask=3'b011 -> passes, fail_cnt=0.
- res_ready held low for 5 cycles -> res_valid, res_resp and res_idx stable; pat_ready=0 throughout; next vector accepted only after the handshake.
- CNT_W=2, 6 failing vectors -> fail_cnt saturates at 3; res_idx wraps 3->0.
- abort asserted in WAIT and again together with res_ready in REPORT -> IDLE next cycle, dut_abcd=0, res_valid=0, no done pulse; a subsequent start re-clears fail_cnt to 0.
